// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-history speculation tracker.
// Holds the default K/M widths, the in-flight entry layout and the GHR shift helper.
// Contains no logic of its own. It is imported by the tracker and its FIFO.
package bp_pkg;

    localparam int BP_K      = 4;   // default PC-derived index width
    localparam int BP_M      = 4;   // default history length
    localparam int BP_HIST_W = 32;  // widest history the shift helper handles

    // One in-flight branch at the default widths: index, history at predict time, predicted bit.
    typedef struct packed {
        logic [BP_K-1:0] index;
        logic [BP_M-1:0] bhr;
        logic            pred;
    } inflight_entry_t;

    // Shift a history left by one and insert the newest outcome at bit 0.
    // Callers zero-extend their M-bit history and keep the low M bits of the result.
    function automatic logic [BP_HIST_W-1:0] ghr_shift(input logic [BP_HIST_W-1:0] hist,
                                                       input logic                 b);
        return (hist << 1) | BP_HIST_W'(b);
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of predicted, unresolved branches; DEPTH entries of WIDTH bits.
// Latency: a push is visible at head_dat_o the cycle after it lands, and a pop frees its slot one cycle later.
// Backpressure: push is ignored when full and pop is ignored when empty. flush_i empties the queue and beats a same-cycle push or pop.
// Ports: clk, reset (async, active-high), push_i/push_dat_i, pop_i, flush_i, head_dat_o, count_o, full_o, empty_o.
module bp_inflight_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    // The pointers wrap naturally because DEPTH is a power of two. The separate count tells full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset. An entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/bhr_spec_tracker.sv
// Speculative global-history owner for the MxN pattern-history predictor. It queues predicted branches and emits PHT training and mispredict on resolve.
// Latency: bhr_out updates the cycle after a prediction. upd_* and mispredict appear one cycle after res_valid.
// Backpressure: pred_ready drops when DEPTH branches are in flight, and a same-cycle pop does not reopen it. A mispredict flushes the queue and drops a same-cycle prediction.
// Ports: clk, reset (async, active-high), pred_* in, bhr_out, res_* in, upd_*, mispredict, inflight_cnt.
// Optional: BHR_TRACKER_STATS_EN adds saturating 16-bit resolved_cnt / mispred_cnt outputs.
module bhr_spec_tracker
    import bp_pkg::*;
#(
    parameter int K     = BP_K,
    parameter int M     = BP_M,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_valid,
    output logic                       pred_ready,
    input  logic [K-1:0]               pred_index,
    input  logic                       pred_taken,
    output logic [M-1:0]               bhr_out,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       upd_valid,
    output logic [K-1:0]               upd_index,
    output logic [M-1:0]               upd_bhr,
    output logic                       upd_outcome,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     inflight_cnt
`ifdef BHR_TRACKER_STATS_EN
    ,
    output logic [15:0]                resolved_cnt,
    output logic [15:0]                mispred_cnt
`endif
);
    // Entry packing is {index, bhr, pred} and matches inflight_entry_t at default widths.
    localparam int EW = K + M + 1;

    logic [M-1:0]  ghr_q, ghr_d;
    logic [EW-1:0] head_dat;
    logic [K-1:0]  head_index;
    logic [M-1:0]  head_bhr;
    logic          head_pred;
    logic          fifo_full, fifo_empty;
    logic          do_res, do_mis, do_push;

    logic          upd_valid_q, upd_outcome_q, mispredict_q;
    logic [K-1:0]  upd_index_q;
    logic [M-1:0]  upd_bhr_q;

    assign head_index = head_dat[EW-1 -: K];
    assign head_bhr   = head_dat[M:1];
    assign head_pred  = head_dat[0];

    assign pred_ready = !fifo_full;
    assign do_res     = res_valid && !fifo_empty;
    assign do_mis     = do_res && (res_taken != head_pred);
    // A mispredict squashes everything younger, including a branch predicted in the same cycle.
    assign do_push    = pred_valid && pred_ready && !do_mis;

    bp_inflight_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (do_push),
        .push_dat_i ({pred_index, ghr_q, pred_taken}),
        .pop_i      (do_res),
        .flush_i    (do_mis),
        .head_dat_o (head_dat),
        .count_o    (inflight_cnt),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // On a mispredict the history is rebuilt from the snapshot taken when the branch was predicted, plus the real outcome.
    always_comb begin
        ghr_d = ghr_q;
        if (do_mis)
            ghr_d = M'(ghr_shift(BP_HIST_W'(head_bhr), res_taken));
        else if (do_push)
            ghr_d = M'(ghr_shift(BP_HIST_W'(ghr_q), pred_taken));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q         <= '0;
            upd_valid_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            upd_index_q   <= '0;
            upd_bhr_q     <= '0;
            upd_outcome_q <= 1'b0;
        end else begin
            ghr_q        <= ghr_d;
            upd_valid_q  <= do_res;
            mispredict_q <= do_mis;
            // The data fields keep their last values between updates.
            if (do_res) begin
                upd_index_q   <= head_index;
                upd_bhr_q     <= head_bhr;
                upd_outcome_q <= res_taken;
            end
        end
    end

    assign bhr_out     = ghr_q;
    assign upd_valid   = upd_valid_q;
    assign mispredict  = mispredict_q;
    assign upd_index   = upd_index_q;
    assign upd_bhr     = upd_bhr_q;
    assign upd_outcome = upd_outcome_q;

`ifdef BHR_TRACKER_STATS_EN
    logic [15:0] resolved_cnt_q, mispred_cnt_q;

    // The counters follow the registered pulses, so they move one cycle after the update is visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resolved_cnt_q <= '0;
            mispred_cnt_q  <= '0;
        end else begin
            if (upd_valid_q && (resolved_cnt_q != 16'hFFFF))
                resolved_cnt_q <= resolved_cnt_q + 16'd1;
            if (mispredict_q && (mispred_cnt_q != 16'hFFFF))
                mispred_cnt_q <= mispred_cnt_q + 16'd1;
        end
    end

    assign resolved_cnt = resolved_cnt_q;
    assign mispred_cnt  = mispred_cnt_q;
`endif

endmodule
